// File: rtl/uart_string_check_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_string_check_if
// Description : Byte-strobe input and match/error status bundle for the
//               UART ID-string checker.
// Revision    : 1.0
// ============================================================================
interface uart_string_check_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             clr_cnt;
    logic             match;
    logic             error;
    logic             busy;
    logic [3:0]       index;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_data, clr_cnt,
        input  match, error, busy, index, match_cnt, err_cnt
    );

    modport slave (
        input  in_valid, in_data, clr_cnt,
        output match, error, busy, index, match_cnt, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_string_check.sv
`default_nettype none
// ============================================================================
// Module      : uart_string_check
// Description : Matches received UART bytes against the ID string
//               "hitsz2024311259"; pulses match/error and keeps counters.
// Revision    : 1.0
// ============================================================================
module uart_string_check #(
    parameter int TIMEOUT = 1_000_000,
    parameter int CNT_W   = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_string_check_if.slave bus
);

    localparam int GAP_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [0:0]       ST_IDLE    = 1'b0;
    localparam logic [0:0]       ST_RECV    = 1'b1;
    localparam logic [7:0]       C_START    = 8'h68;
    localparam logic [3:0]       C_LAST_IDX = 4'd14;
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    logic [0:0]       r_state_q, w_state_d;
    logic [3:0]       r_index_q, w_index_d;
    logic [GAP_W-1:0] r_gap_q,   w_gap_d;
    logic             r_match_q, w_match_d;
    logic             r_error_q, w_error_d;
    logic             r_busy_q,  w_busy_d;
    logic [CNT_W-1:0] r_mcnt_q,  w_mcnt_d;
    logic [CNT_W-1:0] r_ecnt_q,  w_ecnt_d;

    function automatic logic [7:0] f_expected(input logic [3:0] idx);
        case (idx)
            4'd0:    f_expected = 8'h68;
            4'd1:    f_expected = 8'h69;
            4'd2:    f_expected = 8'h74;
            4'd3:    f_expected = 8'h73;
            4'd4:    f_expected = 8'h7A;
            4'd5:    f_expected = 8'h32;
            4'd6:    f_expected = 8'h30;
            4'd7:    f_expected = 8'h32;
            4'd8:    f_expected = 8'h34;
            4'd9:    f_expected = 8'h33;
            4'd10:   f_expected = 8'h31;
            4'd11:   f_expected = 8'h31;
            4'd12:   f_expected = 8'h32;
            4'd13:   f_expected = 8'h35;
            4'd14:   f_expected = 8'h39;
            default: f_expected = 8'h00;
        endcase
    endfunction

    always_comb begin
        w_state_d = r_state_q;
        w_index_d = r_index_q;
        w_gap_d   = r_gap_q;
        w_match_d = 1'b0;
        w_error_d = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                w_gap_d = '0;
                if (bus.in_valid && (bus.in_data == C_START)) begin
                    w_index_d = 4'd1;
                    w_state_d = ST_RECV;
                end
            end
            default: begin
                // A byte arriving on the timeout edge takes precedence.
                if (bus.in_valid) begin
                    w_gap_d = '0;
                    if (bus.in_data == f_expected(r_index_q)) begin
                        if (r_index_q == C_LAST_IDX) begin
                            w_match_d = 1'b1;
                            w_index_d = 4'd0;
                            w_state_d = ST_IDLE;
                        end else begin
                            w_index_d = r_index_q + 4'd1;
                        end
                    end else begin
                        w_error_d = 1'b1;
                        if (bus.in_data == C_START) begin
                            w_index_d = 4'd1;
                        end else begin
                            w_index_d = 4'd0;
                            w_state_d = ST_IDLE;
                        end
                    end
                end else if (r_gap_q == C_GAP_LAST) begin
                    w_error_d = 1'b1;
                    w_index_d = 4'd0;
                    w_gap_d   = '0;
                    w_state_d = ST_IDLE;
                end else begin
                    w_gap_d = r_gap_q + GAP_W'(1);
                end
            end
        endcase

        w_busy_d = (w_state_d == ST_RECV);

        w_mcnt_d = r_mcnt_q;
        w_ecnt_d = r_ecnt_q;
        if (w_match_d && (r_mcnt_q != C_CNT_MAX)) begin
            w_mcnt_d = r_mcnt_q + CNT_W'(1);
        end
        if (w_error_d && (r_ecnt_q != C_CNT_MAX)) begin
            w_ecnt_d = r_ecnt_q + CNT_W'(1);
        end
        if (bus.clr_cnt) begin
            w_mcnt_d = '0;
            w_ecnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_index_q <= 4'd0;
            r_gap_q   <= '0;
            r_match_q <= 1'b0;
            r_error_q <= 1'b0;
            r_busy_q  <= 1'b0;
            r_mcnt_q  <= '0;
            r_ecnt_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_index_q <= w_index_d;
            r_gap_q   <= w_gap_d;
            r_match_q <= w_match_d;
            r_error_q <= w_error_d;
            r_busy_q  <= w_busy_d;
            r_mcnt_q  <= w_mcnt_d;
            r_ecnt_q  <= w_ecnt_d;
        end
    end

    assign bus.match     = r_match_q;
    assign bus.error     = r_error_q;
    assign bus.busy      = r_busy_q;
    assign bus.index     = r_index_q;
    assign bus.match_cnt = r_mcnt_q;
    assign bus.err_cnt   = r_ecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_string_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_string_check
// Description : Directed and randomized bench for uart_string_check against
//               a behavioural string-position model.
// Revision    : 1.0
// ============================================================================
module tb_uart_string_check;

    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_string_check_if #(.CNT_W(CNT_W)) bus ();

    uart_string_check #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    string      id_str = "hitsz2024311259";
    logic [7:0] id_b [15];

    // Model: position in the string (bytes matched), consecutive idle cycles
    int m_pos, m_idle, m_mc, m_ec;
    bit m_match, m_err;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit c, input bit r);
        if (r) begin
            m_pos = 0; m_idle = 0; m_match = 0; m_err = 0; m_mc = 0; m_ec = 0;
            return;
        end
        m_match = 0;
        m_err   = 0;
        if (m_pos == 0) begin
            m_idle = 0;
            if (v && d == id_b[0]) m_pos = 1;
        end else if (v) begin
            m_idle = 0;
            if (d == id_b[m_pos]) begin
                m_pos++;
                if (m_pos == 15) begin
                    m_match = 1;
                    m_pos   = 0;
                end
            end else begin
                m_err = 1;
                m_pos = (d == id_b[0]) ? 1 : 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_err  = 1;
                m_pos  = 0;
                m_idle = 0;
            end
        end
        if (m_match) m_mc = (m_mc < CNT_MAX) ? m_mc + 1 : CNT_MAX;
        if (m_err)   m_ec = (m_ec < CNT_MAX) ? m_ec + 1 : CNT_MAX;
        if (c) begin
            m_mc = 0;
            m_ec = 0;
        end
    endtask

    task automatic tick(input bit v, input logic [7:0] d, input bit c, input bit r);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clr_cnt  = c;
        rst          = r;
        @(posedge clk);
        model_step(v, d, c, r);
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(id_b[i]);
    endtask

    task automatic clear();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("match",     bus.match,     m_match);
            chk("error",     bus.error,     m_err);
            chk("busy",      bus.busy,      (m_pos != 0));
            chk("index",     bus.index,     m_pos);
            chk("match_cnt", bus.match_cnt, m_mc);
            chk("err_cnt",   bus.err_cnt,   m_ec);
        end
    end

    initial begin
        int k;
        for (int i = 0; i < 15; i++) id_b[i] = id_str[i];
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.clr_cnt  = 1'b0;

        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_index", bus.index, 0);
        chk("rst_busy",  bus.busy,  0);
        chk("rst_mcnt",  bus.match_cnt, 0);
        chk("rst_ecnt",  bus.err_cnt, 0);

        // Full string with 10-cycle gaps
        for (int i = 0; i < 15; i++) begin
            send(id_b[i]);
            if (i < 14) idle(10);
        end
        chk("t1_match_pulse", bus.match, 1);
        idle(1);
        chk("t1_match_once", bus.match, 0);
        chk("t1_mcnt", bus.match_cnt, 1);
        chk("t1_ecnt", bus.err_cnt, 0);
        chk("t1_busy", bus.busy, 0);

        // Mismatch aborts to idle
        clear();
        send(8'h68); send(8'h69); send(8'h74); send(8'h58);
        chk("t2_error", bus.error, 1);
        chk("t2_ecnt",  bus.err_cnt, 1);
        chk("t2_index", bus.index, 0);
        chk("t2_busy",  bus.busy, 0);

        // Resync on a new start byte
        clear();
        send(8'h68); send(8'h69); send(8'h68);
        chk("t3_error", bus.error, 1);
        chk("t3_busy",  bus.busy, 1);
        chk("t3_index", bus.index, 1);
        send_range(1, 14);
        chk("t3_match", bus.match, 1);
        chk("t3_mcnt",  bus.match_cnt, 1);
        chk("t3_ecnt",  bus.err_cnt, 1);

        // Inter-byte timeout
        send(8'h68); send(8'h69);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            idle(1);
            if (bus.error === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("t4_timeout_cycles", k, TIMEOUT);
        chk("t4_busy", bus.busy, 0);
        send(8'h68); send(8'h69);
        idle(TIMEOUT - 1);
        send(id_b[2]);
        chk("t4_edge_no_error", bus.error, 0);
        chk("t4_edge_index", bus.index, 3);
        send(8'h58);

        // Noise in idle, then a full string
        clear();
        send(8'h00); send(8'hFF); send(8'h55);
        send_range(0, 14);
        chk("t5_mcnt", bus.match_cnt, 1);
        chk("t5_ecnt", bus.err_cnt, 0);
        for (int n = 0; n < 300; n++) send_range(0, 14);
        idle(1);
        chk("t5_mcnt_sat", bus.match_cnt, 255);

        // Reset mid-string
        send_range(0, 6);
        chk("t6_pre_index", bus.index, 7);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t6_rst_index", bus.index, 0);
        chk("t6_rst_busy",  bus.busy, 0);
        chk("t6_rst_pulse", {bus.match, bus.error}, 0);

        // clr_cnt coincident with the final byte
        send_range(0, 0);
        send_range(1, 13);
        tick(1'b1, id_b[14], 1'b1, 1'b0);
        chk("t7_match",  bus.match, 1);
        chk("t7_mcnt",   bus.match_cnt, 0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit         v, c, r;
            logic [7:0] d;
            if ($urandom_range(0, 149) == 0) idle(TIMEOUT + $urandom_range(0, 2) - 1);
            v = ($urandom_range(0, 9) < 6);
            d = ($urandom_range(0, 9) < 9) ? id_b[m_pos] : 8'($urandom);
            c = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 599) == 0);
            tick(v, d, c, r);
        end

        idle(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_string_check.md
Name: uart_string_check

Overview:
- Receive-side checker for the UART ID-string link.
- Consumes bytes from the UART receiver's byte strobe and compares them against the fixed 15-byte ID string "hitsz2024311259".
- Reports a complete match or a mismatch/timeout, and keeps match and error counters for display or debug.
- Sits between the UART RX deserializer and the board LED/seven-segment logic.

Parameters:
- TIMEOUT, 1_000_000, maximum idle clock cycles allowed between consecutive bytes inside a string before abort.
- CNT_W, 8, width of the match and error counters.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  one-cycle strobe; in_data holds a received byte
- in_data  input  8  received byte
- clr_cnt  input  1  synchronous clear of both counters
- match  output  1  one-cycle pulse: full string received correctly
- error  output  1  one-cycle pulse: mismatch or inter-byte timeout
- busy  output  1  high while a string is partially received
- index  output  4  number of bytes matched so far in the current string (0..14)
- match_cnt  output  CNT_W  count of complete matches, saturating
- err_cnt  output  CNT_W  count of errors, saturating

Behaviour:
- Expected bytes, index 0..14: 68 69 74 73 7A 32 30 32 34 33 31 31 32 35 39 (hex).
- Reset (rst high at a clk edge): state IDLE; index, match, error, busy, match_cnt, err_cnt and the gap counter all 0.
- All outputs are registered. match and error assert in the cycle after the edge that sampled the deciding in_valid/timeout, and last exactly one cycle.
- State machine: IDLE, RECV. busy = (state == RECV).
- IDLE:
  - Gap counter held at 0.
  - in_valid with in_data == 68: index <= 1, go to RECV.
  - Any other byte is ignored: no error, stay IDLE. This rejects line noise before a start.
- RECV, on in_valid, gap counter cleared to 0:
  - Byte == expected[index], index < 14: index <= index + 1.
  - Byte == expected[14], index == 14: match pulse; match_cnt++ (saturate at 2^CNT_W-1); index <= 0; go to IDLE.
  - Byte mismatches:
    - error pulse; err_cnt++ (saturating).
    - If in_data == 68: index <= 1, stay RECV (resync on a new start byte).
    - Otherwise: index <= 0, go to IDLE.
- RECV, no in_valid:
  - Gap counter increments.
  - When it reaches TIMEOUT-1: error pulse; err_cnt++; index <= 0; gap counter <= 0; go to IDLE.
- Simultaneous in_valid and timeout edge: in_valid wins; the byte is processed and no timeout error is raised.
- clr_cnt:
  - Sets match_cnt and err_cnt to 0 on that edge.
  - If a match/error event happens on the same edge, clr_cnt wins for the counter, but the match/error pulse is still issued.
  - clr_cnt does not affect state or index.
- Back-to-back strings (in_valid of 68 on the cycle after the final 39) are accepted with no gap.
- in_valid may be asserted on consecutive cycles; every strobe is processed and none are dropped.
- rst mid-string: returns to IDLE with index 0; no match/error pulse is generated.
- Gap counter width is ceil(log2(TIMEOUT)), and it never wraps.

Test Plan:
- Send the 15 expected bytes with a 10-cycle gap after rst -> single match pulse one cycle after the last strobe; match_cnt=1, err_cnt=0, busy low, index=0.
- Send 68 69 74 58 -> error pulse after the 58 strobe; err_cnt=1; index=0, state IDLE; no match.
- Send 68 69 68, then bytes 69..39 (index 1..14) -> error after the second 68, busy stays high, index=1 at that point, then match; match_cnt=1, err_cnt=1.
- TIMEOUT=20: send 68 69 then idle -> error pulse exactly 20 cycles after the 69 strobe; busy low. Repeat with a byte arriving on the timeout edge -> no error.
- Noise 00 FF 55 in IDLE, then a full string -> no error pulses, match_cnt=1. Then 300 matches with CNT_W=8 -> match_cnt saturates at 255.
- Assert rst at index=7 -> next cycle index=0, busy=0, no pulses. Assert clr_cnt coincident with a final byte -> match pulse seen, match_cnt=0.
